fht_result_reader: RTL and testbench
====================================

Name: fht_result_reader

Overview:
- Unloads the transform result from the four-bank FHT RAM of fht_top once the transform completes (oRDY high).
- Drives the bank read addresses and collects the returned words.
- Streams the points out one per beat on a valid/ready interface, either in natural index order (bit-reversal undone in hardware) or in raw storage order.
- It is the read-side counterpart of the RAM loader that writes ADC data in through iWE/iDATA_x/iADDR_WR_x.

Parameters:
- D_BIT, 16, data word width; signed two's complement.
- A_BIT, 8, per-bank address width; total points N = 4 * 2^A_BIT.
- RD_LAT, 1, RAM read latency in clocks from address to data; legal range 1..3.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  asynchronous active-low reset.
- iSTART  in  1  single-cycle request to begin an unload.
- iBITREV  in  1  sampled at start: 1 = natural order, 0 = storage order.
- iRDY_FHT  in  1  level from fht_top oRDY; 1 = RAM holds a valid result.
- oADDR_RD_0..oADDR_RD_3  out  A_BIT each  bank read addresses; all four carry the same value.
- iDATA_0..iDATA_3  in  D_BIT each  bank read data, valid RD_LAT clocks after the address.
- oDATA  out  D_BIT  output sample.
- oINDEX  out  A_BIT+2  index k of the output sample.
- oVALID  out  1  sample valid.
- iREADY  in  1  downstream accepts; a beat completes when oVALID and iREADY are both 1.
- oLAST  out  1  marks beat k = N-1.
- oBUSY  out  1  unload in progress.
- oDONE  out  1  one-cycle pulse after the last beat.
- oERR  out  1  one-cycle pulse on a refused start or an abort.

Behaviour:
- Storage map: point j lives in bank j[1:0], address j[A_BIT+1:2].
- Source index j = bitrev(k, A_BIT+2) when the latched iBITREV = 1, otherwise j = k.
- Reset: all outputs 0, FSM = IDLE, issue counter = 0, output FIFO empty.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: iSTART=1 with iRDY_FHT=1 -> RUN. Latch iBITREV, clear counters, assert oBUSY from the next cycle.
  - IDLE: iSTART=1 with iRDY_FHT=0 -> oERR pulses next cycle; stay in IDLE.
  - RUN: issue one read per cycle while (FIFO count + reads in flight) < FIFO depth. Issuing k = N-1 -> DRAIN.
  - DRAIN: no further reads. On the beat where oLAST is accepted -> DONE.
  - DONE: oDONE=1 and oBUSY=0 for one cycle -> IDLE.
- Read pipeline:
  - A bank-select shift register RD_LAT deep tracks j[1:0] for each issued address.
  - Returned data is the iDATA_x of the tracked bank, pushed into the output FIFO together with k.
- Output FIFO: depth RD_LAT+1, so no returned word is ever dropped. oVALID = FIFO not empty; oDATA, oINDEX, oLAST come from the FIFO head.
- Throughput: 1 beat/clk with iREADY held at 1. First oVALID appears RD_LAT+1 clocks after the iSTART cycle.
- Backpressure: oDATA, oINDEX and oLAST stay stable while oVALID=1 and iREADY=0. Reads stall once credit is exhausted.
- iSTART while oBUSY=1: ignored, no error.
- iRDY_FHT falling while in RUN or DRAIN (a new transform overwrote the RAM): abort.
  - Flush the FIFO and discard in-flight data.
  - oVALID=0 next cycle, oERR pulses, -> IDLE, no oDONE.
- Asynchronous reset mid-operation: immediate return to reset values; any partial stream is lost.
- oADDR_RD_x holds its last value when no read is issued (no glitches toward the RAM).
- Counters wrap is not reachable; the issue counter is A_BIT+2 bits and stops at N-1.

Test Plan:
- A_BIT=2, RD_LAT=1, bank b address a preloaded with 100*b+a, iBITREV=1, iREADY=1 -> oDATA sequence starts 0, 2, 1, 3, 200, 202, 201, 203, 100, …; oINDEX runs 0..15; oLAST on beat 15; oDONE one cycle later; exactly 16 beats.
- Same preload, iBITREV=0 -> oDATA = 0, 100, 200, 300, 1, 101, 201, 301, …, ending at 303.
- RD_LAT=3, iREADY toggling 1,0,0,1 repeatedly -> identical 16-value sequence with no drops or duplicates; oDATA stable on every cycle with iREADY=0.
- iSTART with iRDY_FHT=0 -> oERR pulse, oBUSY stays 0, no oVALID.
- iRDY_FHT deasserted after beat 5 -> oVALID=0 next cycle, oERR pulse, no oDONE; a new iSTART then replays from k=0.
- iRESET=0 asserted mid-stream -> all outputs 0 immediately; after release, a normal run completes with 16 beats.

Source files
------------

// File: rtl/fht_result_reader.sv
// ---------------------------------------------------------------------------
// fht_result_reader
//
// Unloads a finished transform from the four-bank FHT RAM and streams it out
// one point per beat on a valid/ready interface, in natural index order
// (bit reversal undone) or in raw storage order.
//
// Point j is stored in bank j[1:0] at address j[A_BIT+1:2]. For output index
// k the source point is j = bitrev(k) when iBITREV was 1 at start, else j = k.
//
// Ports
//   iCLK, iRESET          clock, asynchronous active-low reset
//   iSTART                single-cycle unload request
//   iBITREV               sampled with iSTART: 1 = natural order, 0 = storage
//   iRDY_FHT              level, 1 = RAM holds a valid result
//   oADDR_RD_0..3         bank read addresses (identical value on all four)
//   iDATA_0..3            bank read data, RD_LAT clocks after the address
//   oDATA/oINDEX/oLAST    output sample, its index k, k = N-1 marker
//   oVALID, iREADY        beat handshake
//   oBUSY                 unload in progress
//   oDONE                 one-cycle pulse after the last beat
//   oERR                  one-cycle pulse on refused start or abort
// ---------------------------------------------------------------------------
module fht_result_reader #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  input  logic             iBITREV,
  input  logic             iRDY_FHT,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic [A_BIT+1:0] oINDEX,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oERR
);

  localparam int K_W   = A_BIT + 2;
  localparam int DEPTH = RD_LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // N-1 = 4*2^A_BIT - 1 is all ones in K_W bits.
  localparam logic [K_W-1:0] K_LAST = {K_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 bitrev_q;
  logic [K_W-1:0]       cnt_q;
  logic [A_BIT-1:0]     addr_q;
  logic                 err_q;

  // Read-tracking pipeline: one stage per clock of RAM latency.
  logic [RD_LAT-1:0]          tag_vld_q;
  logic [RD_LAT-1:0][1:0]     tag_bank_q;
  logic [RD_LAT-1:0][K_W-1:0] tag_k_q;

  logic [D_BIT-1:0] fifo_data_q [DEPTH];
  logic [K_W-1:0]   fifo_k_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;

  logic             start_ok, start_bad, abort;
  logic             push, pop, issue, credit_ok;
  int               occupancy;
  logic [K_W-1:0]   src_j, head_k;
  logic [D_BIT-1:0] ret_data;
  logic [A_BIT-1:0] rd_addr;

  function automatic logic [K_W-1:0] bit_reverse(input logic [K_W-1:0] k);
    logic [K_W-1:0] r;
    for (int i = 0; i < K_W; i++) r[i] = k[K_W-1-i];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign start_ok  = (state_q == S_IDLE) && iSTART && iRDY_FHT;
  assign start_bad = (state_q == S_IDLE) && iSTART && !iRDY_FHT;
  // A new transform overwriting the RAM invalidates everything not yet sent.
  assign abort     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !iRDY_FHT;

  assign oVALID = (fifo_cnt_q != '0);
  assign pop    = oVALID && iREADY;
  assign push   = tag_vld_q[RD_LAT-1];
  assign head_k = fifo_k_q[rd_ptr_q];
  assign src_j  = bitrev_q ? bit_reverse(cnt_q) : cnt_q;

  // Credit counts the slot freed by a same-cycle pop; without it a FIFO of
  // RD_LAT+1 entries could not sustain one beat per clock.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    occupancy = 0;
    occupancy = int'(fifo_cnt_q) + $countones(tag_vld_q) - (pop ? 1 : 0);
    credit_ok = (occupancy < DEPTH);
  end

  always_comb begin
    ret_data = iDATA_0;
    case (tag_bank_q[RD_LAT-1])
      2'd1:    ret_data = iDATA_1;
      2'd2:    ret_data = iDATA_2;
      2'd3:    ret_data = iDATA_3;
      default: ret_data = iDATA_0;
    endcase
  end

  // FSM: state register.
  always_ff @(posedge iCLK or negedge iRESET) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (!iRESET) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                         state_d = S_IDLE;
        else if (issue && cnt_q == K_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                         state_d = S_IDLE;
        else if (pop && head_k == K_LAST)  state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    issue = 1'b0;
    oBUSY = 1'b0;
    oDONE = 1'b0;
    case (state_q)
      S_RUN: begin
        issue = credit_ok;
        oBUSY = 1'b1;
      end
      S_DRAIN: oBUSY = 1'b1;
      S_DONE:  oDONE = 1'b1;
      default: ;
    endcase
  end

  // The address is held between reads so the RAM never sees a spurious one.
  assign rd_addr    = issue ? src_j[K_W-1:2] : addr_q;
  assign oADDR_RD_0 = rd_addr;
  assign oADDR_RD_1 = rd_addr;
  assign oADDR_RD_2 = rd_addr;
  assign oADDR_RD_3 = rd_addr;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      bitrev_q   <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      tag_vld_q  <= '0;
      tag_bank_q <= '0;
      tag_k_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      err_q <= start_bad || abort;

      if (start_ok) begin
        bitrev_q <= iBITREV;
        cnt_q    <= '0;
      end else if (issue && cnt_q != K_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (issue) addr_q <= src_j[K_W-1:2];

      for (int s = RD_LAT - 1; s > 0; s--) begin
        tag_vld_q[s]  <= tag_vld_q[s-1];
        tag_bank_q[s] <= tag_bank_q[s-1];
        tag_k_q[s]    <= tag_k_q[s-1];
      end
      tag_vld_q[0]  <= issue;
      tag_bank_q[0] <= src_j[1:0];
      tag_k_q[0]    <= cnt_q;

      if (abort) begin
        tag_vld_q  <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
          2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by the reset
  // pointers/count and the outputs below are masked while the FIFO is empty.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ret_data;
      fifo_k_q[wr_ptr_q]    <= tag_k_q[RD_LAT-1];
    end
  end

  assign oDATA  = oVALID ? fifo_data_q[rd_ptr_q] : '0;
  assign oINDEX = oVALID ? head_k : '0;
  assign oLAST  = oVALID && (head_k == K_LAST);
  assign oERR   = err_q;

endmodule

// File: tb/tb_fht_result_reader.sv
// ---------------------------------------------------------------------------
// tb_fht_result_reader
//
// Two instances of fht_result_reader (RD_LAT = 1 and RD_LAT = 3, A_BIT = 2,
// N = 16) share one stimulus stream. Each has its own RAM model and its own
// monitor. The stimulus side computes the expected output stream directly
// from the storage map and pushes it into a per-instance queue; the monitors
// pop and compare on every accepted beat.
// ---------------------------------------------------------------------------
module tb_fht_result_reader;

  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int K_W   = A_BIT + 2;
  localparam int N     = 4 << A_BIT;

  typedef struct packed {
    logic [D_BIT-1:0] data;
    logic [K_W-1:0]   idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, istart, ibitrev, irdy, iready;

  logic [1:0]                  ovalid, olast, obusy, odone, oerr;
  logic [1:0][D_BIT-1:0]       odata;
  logic [1:0][K_W-1:0]         oindex;
  logic [1:0][3:0][A_BIT-1:0]  addr;

  logic [D_BIT-1:0] mem [4][1 << A_BIT];

  exp_t exp_q [2][$];
  int   beats    [2];
  int   done_cnt [2];
  int   err_cnt  [2];
  int   last_edge[2];
  bit   lat_arm  [2];
  int   edge_no = 0;
  int   start_edge = 0;
  int   ready_mode = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_no++;
  end

  task automatic check(input string name, input bit ok, input longint got, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference index permutation: reverse the K_W binary digits of k.
  function automatic int bitrev_k(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < K_W; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- DUTs
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int RDL = (g == 0) ? 1 : 3;
    logic [3:0][A_BIT-1:0] apipe [RDL];
    logic [3:0][D_BIT-1:0] rdata;
    logic                  held_v;
    logic [D_BIT-1:0]      held_d;
    logic [K_W-1:0]        held_i;
    logic                  held_l;
    exp_t                  e;

    fht_result_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RDL)) u_dut (
      .iCLK(clk), .iRESET(rst_n), .iSTART(istart), .iBITREV(ibitrev), .iRDY_FHT(irdy),
      .oADDR_RD_0(addr[g][0]), .oADDR_RD_1(addr[g][1]),
      .oADDR_RD_2(addr[g][2]), .oADDR_RD_3(addr[g][3]),
      .iDATA_0(rdata[0]), .iDATA_1(rdata[1]), .iDATA_2(rdata[2]), .iDATA_3(rdata[3]),
      .oDATA(odata[g]), .oINDEX(oindex[g]), .oVALID(ovalid[g]), .iREADY(iready),
      .oLAST(olast[g]), .oBUSY(obusy[g]), .oDONE(odone[g]), .oERR(oerr[g])
    );

    // Synchronous RAM with RDL clocks of read latency.
    always @(posedge clk) begin
      apipe[0] <= addr[g];
      for (int s = 1; s < RDL; s++) apipe[s] <= apipe[s-1];
    end

    always_comb begin
      rdata = '0;
      for (int b = 0; b < 4; b++) rdata[b] = mem[b][apipe[RDL-1][b]];
    end

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
      held_v = 1'b0;
      held_d = '0;
      held_i = '0;
      held_l = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          held_v = 1'b0;
        end else begin
          if (held_v)
            check($sformatf("hold_stable_%0d", g),
                  ovalid[g] && odata[g] == held_d && oindex[g] == held_i && olast[g] == held_l,
                  {ovalid[g], odata[g], oindex[g]}, {1'b1, held_d, held_i});
          if (lat_arm[g] && ovalid[g]) begin
            check($sformatf("first_valid_latency_%0d", g), edge_no - start_edge == RDL + 1,
                  edge_no - start_edge, RDL + 1);
            lat_arm[g] = 1'b0;
          end
          if (ovalid[g] && iready) begin
            check($sformatf("beat_expected_%0d", g), exp_q[g].size() > 0, exp_q[g].size(), 1);
            if (exp_q[g].size() > 0) begin
              e = exp_q[g].pop_front();
              check($sformatf("data_k%0d_%0d", e.idx, g), odata[g] == e.data, odata[g], e.data);
              check($sformatf("index_%0d", g), oindex[g] == e.idx, oindex[g], e.idx);
              check($sformatf("last_k%0d_%0d", e.idx, g), olast[g] == e.last, olast[g], e.last);
            end
            beats[g]++;
            if (olast[g]) last_edge[g] = edge_no;
          end
          if (odone[g]) begin
            done_cnt[g]++;
            check($sformatf("done_after_last_%0d", g), edge_no - last_edge[g] == 1 && !obusy[g],
                  {obusy[g], 32'(edge_no - last_edge[g])}, 1);
          end
          if (oerr[g]) err_cnt[g]++;
          held_v = ovalid[g] && !iready && irdy;
          held_d = odata[g];
          held_i = oindex[g];
          held_l = olast[g];
        end
      end
    end
  end

  // ------------------------------------------------------ iREADY driver
  initial begin
    int ph = 0;
    iready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          iready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        2:       iready = 1'($urandom_range(0, 1));
        default: iready = 1'b1;
      endcase
    end
  end

  // ------------------------------------------------------ stimulus tasks
  task automatic fill_pattern();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < (1 << A_BIT); a++) mem[b][a] = D_BIT'(100 * b + a);
  endtask

  task automatic fill_random();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < (1 << A_BIT); a++) mem[b][a] = D_BIT'($urandom);
  endtask

  task automatic push_expected(input bit br);
    for (int k = 0; k < N; k++) begin
      int   j;
      exp_t x;
      j      = br ? bitrev_k(k) : k;
      x.data = mem[j % 4][j / 4];
      x.idx  = K_W'(k);
      x.last = (k == N - 1);
      exp_q[0].push_back(x);
      exp_q[1].push_back(x);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int g = 0; g < 2; g++)
      check($sformatf("%s_outputs_zero_%0d", tag, g),
            {ovalid[g], olast[g], obusy[g], odone[g], oerr[g], odata[g], oindex[g], addr[g]} == '0,
            {ovalid[g], olast[g], obusy[g], odone[g], oerr[g], odata[g], oindex[g]}, 0);
  endtask

  // Pulses iSTART for one cycle; returns #1 after the edge that samples it.
  task automatic do_start(input bit br, input bit rdy, input bit arm);
    @(posedge clk); #1;
    istart  = 1'b1;
    ibitrev = br;
    irdy    = rdy;
    @(posedge clk); #1;
    istart     = 1'b0;
    ibitrev    = ~br;
    start_edge = edge_no;
    if (arm) begin
      lat_arm[0] = 1'b1;
      lat_arm[1] = 1'b1;
    end
  endtask

  task automatic run_full(input bit br, input int mode);
    int d0, d1, b0, b1, e0, e1, cyc;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    b0 = beats[0];    b1 = beats[1];
    e0 = err_cnt[0];  e1 = err_cnt[1];
    ready_mode = mode;
    push_expected(br);
    do_start(br, 1'b1, 1'b1);
    for (int g = 0; g < 2; g++)
      check($sformatf("busy_after_start_%0d", g), obusy[g] && !oerr[g], {obusy[g], oerr[g]}, 2);
    cyc = 0;
    while ((done_cnt[0] == d0 || done_cnt[1] == d1) && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    check("run_completes", cyc < 400, cyc, 400);
    repeat (3) @(posedge clk);
    check("beats_0", beats[0] - b0 == N, beats[0] - b0, N);
    check("beats_1", beats[1] - b1 == N, beats[1] - b1, N);
    check("queues_drained", exp_q[0].size() + exp_q[1].size() == 0,
          exp_q[0].size() + exp_q[1].size(), 0);
    check("single_done", done_cnt[0] - d0 == 1 && done_cnt[1] - d1 == 1,
          (done_cnt[0] - d0) * 16 + (done_cnt[1] - d1), 17);
    check("no_err_in_run", err_cnt[0] == e0 && err_cnt[1] == e1,
          (err_cnt[0] - e0) + (err_cnt[1] - e1), 0);
    ready_mode = 0;
  endtask

  // ------------------------------------------------------ main sequence
  initial begin
    int  cyc, b0, d0, d1, e0, e1;
    bit  any_act;
    rst_n = 1'b0; istart = 1'b0; ibitrev = 1'b0; irdy = 1'b1;
    for (int g = 0; g < 2; g++) begin
      beats[g] = 0; done_cnt[g] = 0; err_cnt[g] = 0; last_edge[g] = 0; lat_arm[g] = 1'b0;
    end
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("after_reset");

    // Natural and storage order, full throughput.
    run_full(1'b1, 0);
    run_full(1'b0, 0);
    // Periodic backpressure 1,0,0,1.
    run_full(1'b1, 1);
    run_full(1'b0, 1);
    // Random contents, random order, random backpressure.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_full(1'($urandom_range(0, 1)), 2);
    end

    // Start refused while the RAM holds no result.
    e0 = err_cnt[0]; e1 = err_cnt[1];
    do_start(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 2; g++)
      check($sformatf("refused_err_%0d", g), oerr[g] && !obusy[g] && !ovalid[g],
            {oerr[g], obusy[g], ovalid[g]}, 4);
    any_act = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      any_act |= (ovalid != '0) || (obusy != '0) || (oerr != '0);
    end
    check("refused_quiet", !any_act, any_act, 0);
    check("refused_err_single", err_cnt[0] - e0 == 1 && err_cnt[1] - e1 == 1,
          (err_cnt[0] - e0) * 16 + (err_cnt[1] - e1), 17);
    irdy = 1'b1;

    // Abort: RAM result withdrawn after beat 5 of the RD_LAT=1 instance.
    fill_pattern();
    b0 = beats[0]; d0 = done_cnt[0]; d1 = done_cnt[1];
    e0 = err_cnt[0]; e1 = err_cnt[1];
    push_expected(1'b1);
    do_start(1'b1, 1'b1, 1'b1);
    cyc = 0;
    while (beats[0] - b0 < 6 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check("abort_reach_beat5", cyc < 200, cyc, 200);
    #1;
    irdy = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++)
      check($sformatf("abort_response_%0d", g), !ovalid[g] && oerr[g] && !obusy[g],
            {ovalid[g], oerr[g], obusy[g]}, 2);
    exp_q[0].delete();
    exp_q[1].delete();
    repeat (10) @(posedge clk);
    check("abort_no_done", done_cnt[0] == d0 && done_cnt[1] == d1,
          (done_cnt[0] - d0) + (done_cnt[1] - d1), 0);
    check("abort_err_single", err_cnt[0] - e0 == 1 && err_cnt[1] - e1 == 1,
          (err_cnt[0] - e0) * 16 + (err_cnt[1] - e1), 17);
    irdy = 1'b1;
    run_full(1'b1, 0);

    // Asynchronous reset in the middle of a stream.
    b0 = beats[0];
    push_expected(1'b0);
    do_start(1'b0, 1'b1, 1'b1);
    cyc = 0;
    while (beats[0] - b0 < 4 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    check("reset_reach_beat3", cyc < 200, cyc, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q[0].delete();
    exp_q[1].delete();
    lat_arm[0] = 1'b0;
    lat_arm[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_full(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
